// File: rtl/truth_table_checker_if.sv
// Bus between a truth-table sweep controller and the gate under test.
// master drives control, golden table and gate response; slave runs the sweep.
interface truth_table_checker_if;
    logic        start;
    logic        abort;
    logic [15:0] expected;
    logic        f_in;
    logic [3:0]  abcd;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic [15:0] miss_mask;

    modport master (
        output start,
        output abort,
        output expected,
        output f_in,
        input  abcd,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_err_idx,
        input  miss_mask
    );

    modport slave (
        input  start,
        input  abort,
        input  expected,
        input  f_in,
        output abcd,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_err_idx,
        output miss_mask
    );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive 4-input truth-table sweep: drives vectors 0..15, samples the gate
// response after a settle window and records mismatches against a latched golden table.
module truth_table_checker #(
    parameter int unsigned SETTLE = 1
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_checker_if.slave bus
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 5;
    localparam int unsigned VEC_N = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SETTLE);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(VEC_N - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = ERR_W'(VEC_N);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VEC_N-1:0] exp_q, exp_d;
    logic [IDX_W-1:0] abcd_q, abcd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [IDX_W-1:0] first_q, first_d;
    logic [VEC_N-1:0] miss_q, miss_d;

    logic sample_c;
    logic mismatch_c;

    assign sample_c   = (cnt_q == HOLD_LAST);
    assign mismatch_c = (bus.f_in != exp_q[idx_q]);

    // Next-state and next-output logic; every register holds unless changed below.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        abcd_d  = abcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        first_d = first_q;
        miss_d  = miss_q;

        case (state_q)
            S_IDLE: begin
                abcd_d = '0;
                busy_d = 1'b0;
                idx_d  = '0;
                cnt_d  = '0;
                // abort outranks start so a cancelled request never launches
                if (bus.start && !bus.abort) begin
                    state_d = S_RUN;
                    exp_d   = bus.expected;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    first_d = '0;
                    miss_d  = '0;
                end
            end

            S_RUN: begin
                if (bus.abort) begin
                    // partial miss_mask/err_count stay visible for debug
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    abcd_d  = '0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (sample_c) begin
                    cnt_d = '0;
                    if (mismatch_c) begin
                        miss_d[idx_q] = 1'b1;
                        if (err_q != ERR_MAX) begin
                            err_d = ERR_W'(err_q + 1'b1);
                        end
                        if (err_q == '0) begin
                            first_d = idx_q;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        abcd_d  = '0;
                        idx_d   = '0;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d  = IDX_W'(idx_q + 1'b1);
                        abcd_d = IDX_W'(idx_q + 1'b1);
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                abcd_d  = '0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                abcd_d  = '0;
                busy_d  = 1'b0;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            abcd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            abcd_q  <= abcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
            miss_q  <= miss_d;
        end
    end

    assign bus.abcd          = abcd_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_idx = first_q;
    assign bus.miss_mask     = miss_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed plus randomized sweeps of truth_table_checker at SETTLE=1 and SETTLE=0,
// checked against a table-level model of the expected sweep results.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    truth_table_checker_if i1 ();
    truth_table_checker_if i0 ();

    truth_table_checker #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
    truth_table_checker #(.SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));

    // gate under test: a response truth table looked up by the applied vector
    logic [15:0] resp1, resp0;
    assign i1.f_in = resp1[i1.abcd];
    assign i0.f_in = resp0[i0.abcd];

    int n_cmp = 0;
    int n_mis = 0;
    int sel   = 1;

    logic [3:0]  m_abcd;
    logic        m_busy, m_done, m_pass;
    logic [4:0]  m_err;
    logic [3:0]  m_first;
    logic [15:0] m_miss;

    always_comb begin
        if (sel == 1) begin
            m_abcd = i1.abcd; m_busy = i1.busy; m_done = i1.done; m_pass = i1.pass;
            m_err = i1.err_count; m_first = i1.first_err_idx; m_miss = i1.miss_mask;
        end else begin
            m_abcd = i0.abcd; m_busy = i0.busy; m_done = i0.done; m_pass = i0.pass;
            m_err = i0.err_count; m_first = i0.first_err_idx; m_miss = i0.miss_mask;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic st, input logic ab, input logic [15:0] ex);
        if (s == 1) begin
            i1.start = st; i1.abort = ab; i1.expected = ex;
        end else begin
            i0.start = st; i0.abort = ab; i0.expected = ex;
        end
    endtask

    // result of comparing the first nvec vectors of a response table to the golden table
    task automatic model(input logic [15:0] ex, input logic [15:0] rsp, input int nvec,
                         output logic [15:0] miss, output logic [4:0] cnt,
                         output logic [3:0] first);
        logic [31:0] m;
        m     = 32'(ex ^ rsp) & ((32'd1 << nvec) - 32'd1);
        miss  = m[15:0];
        cnt   = 5'($countones(miss));
        first = 4'd0;
        for (int i = 15; i >= 0; i--) if (miss[i]) first = 4'(i);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".abcd"}, 32'(m_abcd), 0);
        chk({tag, ".busy"}, 32'(m_busy), 0);
        chk({tag, ".done"}, 32'(m_done), 0);
        chk({tag, ".pass"}, 32'(m_pass), 0);
        chk({tag, ".err"}, 32'(m_err), 0);
        chk({tag, ".first"}, 32'(m_first), 0);
        chk({tag, ".miss"}, 32'(m_miss), 0);
    endtask

    // full sweep; start is re-pulsed at cycle poke_at (if >= 0) and must be ignored
    task automatic sweep(input int s, input logic [15:0] ex, input logic [15:0] rsp,
                         input int poke_at, input string name);
        int h;
        logic [15:0] miss;
        logic [4:0]  cnt;
        logic [3:0]  first;
        h = (s == 1) ? 2 : 1;
        model(ex, rsp, 16, miss, cnt, first);
        sel = s;
        if (s == 1) resp1 = rsp; else resp0 = rsp;
        @(negedge clk);
        drive(s, 1'b1, 1'b0, ex);
        @(posedge clk); #1;
        drive(s, 1'b0, 1'b0, ~ex);
        for (int c = 0; c < 16 * h; c++) begin
            chk($sformatf("%s.abcd[c%0d]", name, c), 32'(m_abcd), 32'(c / h));
            chk($sformatf("%s.busy[c%0d]", name, c), 32'(m_busy), 1);
            if (c == poke_at) drive(s, 1'b1, 1'b0, ~ex);
            else drive(s, 1'b0, 1'b0, ~ex);
            @(posedge clk); #1;
        end
        drive(s, 1'b0, 1'b0, ~ex);
        chk({name, ".done"}, 32'(m_done), 1);
        chk({name, ".busy_done"}, 32'(m_busy), 0);
        chk({name, ".abcd_done"}, 32'(m_abcd), 0);
        chk({name, ".pass"}, 32'(m_pass), 32'(cnt == 5'd0));
        chk({name, ".err"}, 32'(m_err), 32'(cnt));
        chk({name, ".miss"}, 32'(m_miss), 32'(miss));
        if (cnt != 5'd0) chk({name, ".first"}, 32'(m_first), 32'(first));
        @(posedge clk); #1;
        chk({name, ".done_pulse"}, 32'(m_done), 0);
        chk({name, ".busy_idle"}, 32'(m_busy), 0);
        chk({name, ".pass_hold"}, 32'(m_pass), 32'(cnt == 5'd0));
        chk({name, ".err_hold"}, 32'(m_err), 32'(cnt));
        chk({name, ".miss_hold"}, 32'(m_miss), 32'(miss));
    endtask

    initial begin
        logic [15:0] ex, rsp, miss;
        logic [4:0]  cnt;
        logic [3:0]  first;

        rst = 1'b1;
        resp1 = '0; resp0 = '0;
        drive(1, 1'b0, 1'b0, 16'h0);
        drive(0, 1'b0, 1'b0, 16'h0);
        #12;
        sel = 1; #0 chk_outputs_zero("reset1");
        sel = 0; #1 chk_outputs_zero("reset0");

        @(posedge clk); #1;
        rst = 1'b0;

        // start on the first edge after reset release; golden AND
        sweep(1, 16'h8000, 16'h8000, -1, "and_s1");
        sweep(1, 16'h8000, 16'h0000, -1, "stuck0_s1");
        sweep(1, 16'h6996, 16'h9669, -1, "xor_inv_s1");
        for (int i = 0; i < 4; i++)
            sweep(1, 16'($urandom), 16'($urandom), -1, $sformatf("rand_s1_%0d", i));

        sweep(0, 16'h8000, 16'h8000, 7, "and_s0_poke7");
        sweep(0, 16'h6996, 16'h9669, -1, "xor_inv_s0");
        for (int i = 0; i < 3; i++)
            sweep(0, 16'($urandom), 16'($urandom), -1, $sformatf("rand_s0_%0d", i));

        // abort outranks start in IDLE
        sel = 1;
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 16'h1234);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 16'h1234);
        chk("abort_prio.busy", 32'(m_busy), 0);
        @(posedge clk); #1;
        chk("abort_prio.busy2", 32'(m_busy), 0);

        // abort at idx=5: vectors 0..4 recorded, no done pulse
        ex  = 16'($urandom);
        rsp = 16'($urandom) ^ 16'h0015;
        model(ex, rsp, 5, miss, cnt, first);
        resp1 = rsp;
        @(negedge clk);
        drive(1, 1'b1, 1'b0, ex);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, ex);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        chk("abort.abcd5", 32'(m_abcd), 5);
        drive(1, 1'b1, 1'b1, ex);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, ex);
        chk("abort.busy", 32'(m_busy), 0);
        chk("abort.done", 32'(m_done), 0);
        chk("abort.pass", 32'(m_pass), 0);
        chk("abort.abcd", 32'(m_abcd), 0);
        chk("abort.err", 32'(m_err), 32'(cnt));
        chk("abort.miss", 32'(m_miss), 32'(miss));
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("abort.no_done[%0d]", c), 32'(m_done), 0);
        end

        // reset mid-cycle at idx=9, then a fresh sweep right after release
        resp1 = 16'hFFFF;
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 16'h0000);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 16'h0000);
        for (int c = 0; c < 18; c++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid.abcd9", 32'(m_abcd), 9);
        chk("rst_mid.err_before", 32'(m_err), 9);
        #2 rst = 1'b1;
        #1 chk_outputs_zero("rst_mid");
        @(posedge clk); #1;
        chk("rst_mid.no_done", 32'(m_done), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid.no_done_after", 32'(m_done), 0);
        chk("rst_mid.busy_after", 32'(m_busy), 0);
        sweep(1, 16'($urandom), 16'($urandom), -1, "after_rst_s1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
